// File: rtl/axi3_ram_slave_pkg.sv
// Shared definitions for the AXI3 RAM slave: FSM states, burst and response
// encodings, and the request legality check used on both read and write paths.
package axi3_ram_slave_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRdata = 2'd1,
        StWdata = 2'd2,
        StWresp = 2'd3
    } state_e;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Only full-word beats are supported.
    localparam logic [2:0] SIZE_WORD   = 3'b010;

    // Only 32-bit FIXED or INCR bursts are served; anything else gets SLVERR.
    function automatic logic is_legal(input logic [2:0] size, input logic [1:0] burst);
        return (size == SIZE_WORD) && ((burst == BURST_FIXED) || (burst == BURST_INCR));
    endfunction

endpackage

// File: rtl/axi3_ram_bank.sv
// Word-organised RAM with a per-byte write enable and a combinational read.
// Ports:
//   aclk   - clock, writes take effect on the rising edge
//   addr   - word address shared by read and write
//   we     - write enable
//   wstrb  - byte lane enables for the write
//   wdata  - write data
//   rdata  - word at addr, combinational
// Contents are deliberately not reset.
module axi3_ram_bank #(
    parameter int unsigned WORD_AW = 14
) (
    input  logic               aclk,
    input  logic [WORD_AW-1:0] addr,
    input  logic               we,
    input  logic [3:0]         wstrb,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata
);

    logic [31:0] mem [0:(1 << WORD_AW) - 1];

    assign rdata = mem[addr];

    always_ff @(posedge aclk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/axi3_ram_slave.sv
// AXI3 slave fronting a 2^(ADDR_W-2) x 32-bit RAM, one transaction at a time.
// Ports:
//   aclk, aresetn                          - clock, async active-low reset
//   ar* / arvalid / arready                - read request channel
//   rid, rdata, rresp, rlast, rvalid/rready - read data channel
//   aw* / awvalid / awready                - write request channel
//   wid, wdata, wstrb, wlast, wvalid/wready - write data channel (wid ignored)
//   bid, bresp, bvalid / bready            - write response channel
// Illegal requests (size != word, WRAP or reserved burst) are consumed with
// SLVERR and never touch the RAM. Address bits outside [ADDR_W-1:2] alias.
module axi3_ram_slave
    import axi3_ram_slave_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned ID_W   = 4
) (
    input  logic            aclk,
    input  logic            aresetn,

    input  logic [ID_W-1:0] arid,
    input  logic [31:0]     araddr,
    input  logic [7:0]      arlen,
    input  logic [2:0]      arsize,
    input  logic [1:0]      arburst,
    input  logic            arvalid,
    output logic            arready,

    output logic [ID_W-1:0] rid,
    output logic [31:0]     rdata,
    output logic [1:0]      rresp,
    output logic            rlast,
    output logic            rvalid,
    input  logic            rready,

    input  logic [ID_W-1:0] awid,
    input  logic [31:0]     awaddr,
    input  logic [7:0]      awlen,
    input  logic [2:0]      awsize,
    input  logic [1:0]      awburst,
    input  logic            awvalid,
    output logic            awready,

    input  logic [ID_W-1:0] wid,
    input  logic [31:0]     wdata,
    input  logic [3:0]      wstrb,
    input  logic            wlast,
    input  logic            wvalid,
    output logic            wready,

    output logic [ID_W-1:0] bid,
    output logic [1:0]      bresp,
    output logic            bvalid,
    input  logic            bready
);

    localparam int unsigned WORD_AW = ADDR_W - 2;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [WORD_AW-1:0] addr_q, addr_d;
    logic [7:0]         len_q, len_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [2:0]         size_q, size_d;
    logic [1:0]         burst_q, burst_d;
    logic               err_q, err_d;
    // 1 when the read channel won the last arbitration.
    logic               served_rd_q, served_rd_d;

    logic               illegal;
    logic               beat_last;
    logic               both_req;
    logic               ram_we;
    logic [31:0]        ram_rdata;
    logic [WORD_AW-1:0] addr_next;

    logic               unused_bits;
    assign unused_bits = ^{araddr[31:ADDR_W], araddr[1:0], awaddr[31:ADDR_W], awaddr[1:0], wid};

    assign illegal   = !is_legal(size_q, burst_q);
    assign beat_last = (cnt_q == len_q);
    assign both_req  = arvalid && awvalid;
    assign addr_next = (burst_q == BURST_INCR) ? addr_q + 1'b1 : addr_q;

    axi3_ram_bank #(
        .WORD_AW (WORD_AW)
    ) u_bank (
        .aclk  (aclk),
        .addr  (addr_q),
        .we    (ram_we),
        .wstrb (wstrb),
        .wdata (wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= StIdle;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            err_q       <= 1'b0;
            served_rd_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            err_q       <= err_d;
            served_rd_q <= served_rd_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        size_d      = size_q;
        burst_d     = burst_q;
        err_d       = err_q;
        served_rd_d = served_rd_q;

        arready = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        rresp   = RESP_OKAY;
        rdata   = '0;
        bvalid  = 1'b0;
        bresp   = RESP_OKAY;
        ram_we  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Gated by aresetn so both readies drop the moment reset asserts.
                // On contention the channel not served last gets the ready.
                arready = aresetn && !(both_req && served_rd_q);
                awready = aresetn && !(both_req && !served_rd_q);
                if (arvalid && arready) begin
                    id_d        = arid;
                    addr_d      = araddr[ADDR_W-1:2];
                    len_d       = arlen;
                    size_d      = arsize;
                    burst_d     = arburst;
                    cnt_d       = '0;
                    served_rd_d = 1'b1;
                    state_d     = StRdata;
                end else if (awvalid && awready) begin
                    id_d        = awid;
                    addr_d      = awaddr[ADDR_W-1:2];
                    len_d       = awlen;
                    size_d      = awsize;
                    burst_d     = awburst;
                    cnt_d       = '0;
                    err_d       = 1'b0;
                    served_rd_d = 1'b0;
                    state_d     = StWdata;
                end
            end
            StRdata: begin
                rvalid = 1'b1;
                rlast  = beat_last;
                rresp  = illegal ? RESP_SLVERR : RESP_OKAY;
                rdata  = illegal ? 32'h0 : ram_rdata;
                if (rready) begin
                    cnt_d  = cnt_q + 8'd1;
                    addr_d = addr_next;
                    if (beat_last) begin
                        state_d = StIdle;
                    end
                end
            end
            StWdata: begin
                wready = 1'b1;
                if (wvalid) begin
                    ram_we = !illegal;
                    if (wlast != beat_last) begin
                        err_d = 1'b1;
                    end
                    cnt_d  = cnt_q + 8'd1;
                    addr_d = addr_next;
                    if (beat_last) begin
                        state_d = StWresp;
                    end
                end
            end
            StWresp: begin
                bvalid = 1'b1;
                bresp  = (illegal || err_q) ? RESP_SLVERR : RESP_OKAY;
                if (bready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // id_q is reset to zero, so both ids read zero out of reset.
    assign rid = id_q;
    assign bid = id_q;

endmodule

// File: tb/tb_axi3_ram_slave.sv
module tb_axi3_ram_slave;

    logic        aclk;
    logic        aresetn;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int errors = 0;
    int checks = 0;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    axi3_ram_slave #(
        .ADDR_W (16),
        .ID_W   (4)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .arid    (arid),
        .araddr  (araddr),
        .arlen   (arlen),
        .arsize  (arsize),
        .arburst (arburst),
        .arvalid (arvalid),
        .arready (arready),
        .rid     (rid),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .rvalid  (rvalid),
        .rready  (rready),
        .awid    (awid),
        .awaddr  (awaddr),
        .awlen   (awlen),
        .awsize  (awsize),
        .awburst (awburst),
        .awvalid (awvalid),
        .awready (awready),
        .wid     (wid),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wlast   (wlast),
        .wvalid  (wvalid),
        .wready  (wready),
        .bid     (bid),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic apply_reset;
        @(negedge aclk);
        aresetn = 1'b0;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; rready = 1'b0; bready = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic ar_req(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        int n;
        @(negedge aclk);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        #1;
        n = 0;
        while (!arready && n < 20) begin @(negedge aclk); #1; n++; end
        checks++;
        if (!arready) begin errors++; $display("FAIL ar_handshake arready=%b want 1", arready); end
        @(posedge aclk);
        #1 arvalid = 1'b0;
    endtask

    task automatic aw_req(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        int n;
        @(negedge aclk);
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        #1;
        n = 0;
        while (!awready && n < 20) begin @(negedge aclk); #1; n++; end
        checks++;
        if (!awready) begin errors++; $display("FAIL aw_handshake awready=%b want 1", awready); end
        @(posedge aclk);
        #1 awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n;
        @(negedge aclk);
        wid = 4'hF; wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        #1;
        n = 0;
        while (!wready && n < 20) begin @(negedge aclk); #1; n++; end
        checks++;
        if (!wready) begin errors++; $display("FAIL w_handshake wready=%b want 1", wready); end
        @(posedge aclk);
        #1 wvalid = 1'b0;
    endtask

    task automatic r_beat(input logic [3:0] eid, input logic [31:0] edata, input logic [1:0] eresp,
                          input logic elast, input string name);
        int n;
        @(negedge aclk);
        rready = 1'b1;
        #1;
        n = 0;
        while (!rvalid && n < 20) begin @(negedge aclk); #1; n++; end
        checks++;
        if (!rvalid) begin
            errors++; $display("FAIL %s timeout rvalid=0 want 1", name);
        end else if ({rid, rresp, rlast, rdata} !== {eid, eresp, elast, edata}) begin
            errors++;
            $display("FAIL %s got id=%h resp=%b last=%b data=%h want id=%h resp=%b last=%b data=%h",
                     name, rid, rresp, rlast, rdata, eid, eresp, elast, edata);
        end
        @(posedge aclk);
        #1 rready = 1'b0;
    endtask

    task automatic b_resp(input logic [3:0] eid, input logic [1:0] eresp, input string name);
        int n;
        @(negedge aclk);
        bready = 1'b1;
        #1;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge aclk); #1; n++; end
        checks++;
        if (!bvalid) begin
            errors++; $display("FAIL %s timeout bvalid=0 want 1", name);
        end else if ({bid, bresp} !== {eid, eresp}) begin
            errors++;
            $display("FAIL %s got bid=%h bresp=%b want bid=%h bresp=%b", name, bid, bresp, eid, eresp);
        end
        @(posedge aclk);
        #1 bready = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        checks++;
        if ({arready, awready, wready, rvalid, bvalid, rlast, rresp, bresp, rid, bid} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs got ar=%b aw=%b w=%b rv=%b bv=%b rl=%b rr=%b br=%b rid=%h bid=%h want all 0",
                     arready, awready, wready, rvalid, bvalid, rlast, rresp, bresp, rid, bid);
        end
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        #1;
        checks++;
        if ({arready, awready, rvalid, bvalid} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_release got ar=%b aw=%b rv=%b bv=%b want 1100",
                     arready, awready, rvalid, bvalid);
        end
    endtask

    // Seed word 4 so the first read after a fresh reset has a known value.
    task automatic test_init;
        aw_req(4'd1, 32'h10, 8'd0, 3'b010, 2'b01);
        w_beat(32'hC0DE_0004, 4'hF, 1'b1);
        b_resp(4'd1, OKAY, "init_bresp");
        apply_reset();
    endtask

    task automatic test_single_read;
        ar_req(4'd3, 32'h10, 8'd0, 3'b010, 2'b01);
        r_beat(4'd3, 32'hC0DE_0004, OKAY, 1'b1, "single_read");
    endtask

    task automatic test_burst;
        aw_req(4'd5, 32'h100, 8'd3, 3'b010, 2'b01);
        for (int i = 0; i < 4; i++) w_beat(32'hA0 + i, 4'hF, i == 3);
        b_resp(4'd5, OKAY, "burst_bresp");
        ar_req(4'd6, 32'h100, 8'd3, 3'b010, 2'b01);
        for (int i = 0; i < 4; i++) r_beat(4'd6, 32'hA0 + i, OKAY, i == 3, "burst_read");
    endtask

    task automatic test_strobe;
        aw_req(4'd2, 32'h200, 8'd0, 3'b010, 2'b01);
        w_beat(32'hFFFF_FFFF, 4'hF, 1'b1);
        b_resp(4'd2, OKAY, "strobe_fill_bresp");
        aw_req(4'd2, 32'h200, 8'd0, 3'b010, 2'b01);
        w_beat(32'h1122_3344, 4'b0101, 1'b1);
        b_resp(4'd2, OKAY, "strobe_bresp");
        ar_req(4'd2, 32'h200, 8'd0, 3'b010, 2'b01);
        r_beat(4'd2, 32'hFF22_FF44, OKAY, 1'b1, "strobe_read");
    endtask

    task automatic test_illegal;
        ar_req(4'd2, 32'h100, 8'd1, 3'b001, 2'b01);
        r_beat(4'd2, 32'h0, SLVERR, 1'b0, "bad_size_beat0");
        r_beat(4'd2, 32'h0, SLVERR, 1'b1, "bad_size_beat1");
        // Early wlast: both beats still land, response flags the framing error.
        aw_req(4'd9, 32'h180, 8'd1, 3'b010, 2'b01);
        w_beat(32'h0000_DEAD, 4'hF, 1'b1);
        w_beat(32'h0000_BEEF, 4'hF, 1'b1);
        b_resp(4'd9, SLVERR, "early_wlast_bresp");
        ar_req(4'd9, 32'h180, 8'd1, 3'b010, 2'b01);
        r_beat(4'd9, 32'h0000_DEAD, OKAY, 1'b0, "early_wlast_kept0");
        r_beat(4'd9, 32'h0000_BEEF, OKAY, 1'b1, "early_wlast_kept1");
        aw_req(4'd1, 32'h180, 8'd0, 3'b010, 2'b10);
        w_beat(32'h1234_5678, 4'hF, 1'b1);
        b_resp(4'd1, SLVERR, "wrap_write_bresp");
        // FIXED burst re-reads the same word; also shows the WRAP write was dropped.
        ar_req(4'd1, 32'h180, 8'd1, 3'b010, 2'b00);
        r_beat(4'd1, 32'h0000_DEAD, OKAY, 1'b0, "fixed_read0");
        r_beat(4'd1, 32'h0000_DEAD, OKAY, 1'b1, "fixed_read1");
    endtask

    task automatic test_arbitration;
        apply_reset();
        @(negedge aclk);
        arid = 4'd7; araddr = 32'h100; arlen = 8'd3; arsize = 3'b010; arburst = 2'b01;
        awid = 4'd8; awaddr = 32'h300; awlen = 8'd0; awsize = 3'b010; awburst = 2'b01;
        arvalid = 1'b1; awvalid = 1'b1;
        #1;
        checks++;
        if ({arready, awready} !== 2'b10) begin
            errors++; $display("FAIL arb_first got ar=%b aw=%b want ar=1 aw=0", arready, awready);
        end
        @(posedge aclk);
        #1 arvalid = 1'b0;
        @(negedge aclk);
        #1;
        checks++;
        if (awready !== 1'b0) begin
            errors++; $display("FAIL arb_busy awready=%b want 0", awready);
        end
        r_beat(4'd7, 32'hA0, OKAY, 1'b0, "arb_beat0");
        r_beat(4'd7, 32'hA1, OKAY, 1'b0, "arb_beat1");
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            #1;
            checks++;
            if ({rvalid, rid, rresp, rlast, rdata} !== {1'b1, 4'd7, OKAY, 1'b0, 32'hA2}) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got rv=%b id=%h resp=%b last=%b data=%h want rv=1 id=7 resp=00 last=0 data=000000a2",
                         i, rvalid, rid, rresp, rlast, rdata);
            end
        end
        r_beat(4'd7, 32'hA2, OKAY, 1'b0, "arb_beat2");
        r_beat(4'd7, 32'hA3, OKAY, 1'b1, "arb_beat3");
        aw_req(4'd8, 32'h300, 8'd0, 3'b010, 2'b01);
        w_beat(32'h55, 4'hF, 1'b1);
        b_resp(4'd8, OKAY, "arb_write_bresp");
        ar_req(4'd8, 32'h300, 8'd0, 3'b010, 2'b01);
        r_beat(4'd8, 32'h55, OKAY, 1'b1, "arb_write_read");
    endtask

    task automatic test_wrap_reset;
        aw_req(4'd4, 32'hFFFC, 8'd3, 3'b010, 2'b01);
        for (int i = 0; i < 4; i++) w_beat(32'hE0 + i, 4'hF, i == 3);
        b_resp(4'd4, OKAY, "wrap_bresp");
        ar_req(4'd4, 32'hFFFC, 8'd3, 3'b010, 2'b01);
        for (int i = 0; i < 4; i++) r_beat(4'd4, 32'hE0 + i, OKAY, i == 3, "wrap_read");
        // Alias check: upper address bits are ignored, word 0 reads back E1.
        ar_req(4'd4, 32'h0001_0002, 8'd0, 3'b010, 2'b01);
        r_beat(4'd4, 32'hE1, OKAY, 1'b1, "alias_read");
        ar_req(4'd5, 32'hFFFC, 8'd3, 3'b010, 2'b01);
        r_beat(4'd5, 32'hE0, OKAY, 1'b0, "rst_beat0");
        r_beat(4'd5, 32'hE1, OKAY, 1'b0, "rst_beat1");
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        checks++;
        if (rvalid !== 1'b0) begin
            errors++; $display("FAIL midburst_reset rvalid=%b want 0", rvalid);
        end
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        #1;
        checks++;
        if ({arready, rvalid} !== 2'b10) begin
            errors++; $display("FAIL post_reset got arready=%b rvalid=%b want 1 0", arready, rvalid);
        end
        ar_req(4'd6, 32'h8, 8'd0, 3'b010, 2'b01);
        r_beat(4'd6, 32'hE3, OKAY, 1'b1, "post_reset_read");
    endtask

    initial begin
        aresetn = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        rready = 1'b0; bready = 1'b0;
        test_reset();
        test_init();
        test_single_read();
        test_burst();
        test_strobe();
        test_illegal();
        test_arbitration();
        test_wrap_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
